// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweep checker.
package tt_sweep_checker_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Hold counter is wide enough for the largest legal SETTLE (15).
   localparam int HOLD_W = 4;

   function automatic logic hold_done(input logic [HOLD_W-1:0] hold, input int settle);
      return (hold == HOLD_W'(settle));
   endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Controller/DUT-facing bundle of the sweep checker; slave = checker, master = environment.
interface tt_sweep_checker_if #(
   parameter int N_IN = 3
);
   localparam int NVEC = 1 << N_IN;

   logic              start;
   logic [NVEC-1:0]   expected;
   logic [N_IN-1:0]   dut_in;
   logic              dut_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     mismatch_cnt;
   logic [N_IN-1:0]   first_fail;
   logic [NVEC-1:0]   captured;

   modport slave (
      input  start, expected, dut_out,
      output dut_in, busy, done, pass, mismatch_cnt, first_fail, captured
   );

   modport master (
      output start, expected, dut_out,
      input  dut_in, busy, done, pass, mismatch_cnt, first_fail, captured
   );

endinterface

// File: rtl/tt_sweep_checker.sv
// Drives every input vector in ascending order, samples the 1-bit response after
// SETTLE extra cycles and compares the observed truth table with a snapshotted one.
module tt_sweep_checker
   import tt_sweep_checker_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   tt_sweep_checker_if.slave sweep_if
);

   localparam int              NVEC     = 1 << N_IN;
   localparam int              CNT_W    = N_IN + 1;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

   state_e             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [N_IN-1:0]    vec_q, vec_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   mcnt_q, mcnt_d;
   logic [N_IN-1:0]    ffail_q, ffail_d;
   logic [NVEC-1:0]    capt_q, capt_d;
   logic [NVEC-1:0]    exp_q, exp_d;

   logic accept_s, sample_s, last_s, miss_s;

   assign accept_s = (state_q == ST_IDLE) && sweep_if.start;
   assign sample_s = (state_q == ST_RUN) && hold_done(hold_q, SETTLE);
   assign last_s   = (vec_q == LAST_VEC);
   assign miss_s   = (sweep_if.dut_out != exp_q[vec_q]);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (sample_s && last_s) state_d = ST_IDLE;
            else                    state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: accept clears results, sample edges capture and compare
   always_comb begin
      hold_d  = hold_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      mcnt_d  = mcnt_q;
      ffail_d = ffail_q;
      capt_d  = capt_q;
      exp_d   = exp_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               exp_d   = sweep_if.expected;
               busy_d  = 1'b1;
               vec_d   = '0;
               hold_d  = '0;
               capt_d  = '0;
               mcnt_d  = '0;
               ffail_d = '0;
               pass_d  = 1'b0;
            end else begin
               busy_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (!sample_s) begin
               hold_d = hold_q + HOLD_W'(1);
            end else begin
               capt_d[vec_q] = sweep_if.dut_out;
               mcnt_d        = mcnt_q + CNT_W'(miss_s);
               // Only the very first mismatch of a sweep is recorded.
               if (miss_s && (mcnt_q == '0)) ffail_d = vec_q;
               else                          ffail_d = ffail_q;
               if (last_s) begin
                  vec_d  = '0;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  pass_d = (mcnt_d == '0);
               end else begin
                  vec_d  = vec_q + N_IN'(1);
                  hold_d = '0;
               end
            end
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q  <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mcnt_q  <= '0;
         ffail_q <= '0;
         capt_q  <= '0;
         exp_q   <= '0;
      end else begin
         hold_q  <= hold_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mcnt_q  <= mcnt_d;
         ffail_q <= ffail_d;
         capt_q  <= capt_d;
         exp_q   <= exp_d;
      end
   end

   assign sweep_if.dut_in       = vec_q;
   assign sweep_if.busy         = busy_q;
   assign sweep_if.done         = done_q;
   assign sweep_if.pass         = pass_q;
   assign sweep_if.mismatch_cnt = mcnt_q;
   assign sweep_if.first_fail   = ffail_q;
   assign sweep_if.captured     = capt_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (N_IN=3/SETTLE=1 and N_IN=1/SETTLE=0) against a truth-table model.
module tb_tt_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_v [2];
   logic [7:0] exp_v   [2];
   int         mode_v  [2];
   int         n_vec  = 0;
   int         n_miss = 0;

   tt_sweep_checker_if #(.N_IN(3)) if_a ();
   tt_sweep_checker_if #(.N_IN(1)) if_b ();

   tt_sweep_checker #(.N_IN(3), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .sweep_if(if_a.slave));
   tt_sweep_checker #(.N_IN(1), .SETTLE(0)) dut_b (.clk(clk), .rst_n(rst_n), .sweep_if(if_b.slave));

   // Behavioural device under sweep: 0 majority, 1 stuck-at-0, 2 NOT, 3 buffer
   function automatic logic dut_fn(input int mode, input logic [7:0] x);
      case (mode)
         0:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
         1:       return 1'b0;
         2:       return ~x[0];
         default: return x[0];
      endcase
   endfunction

   function automatic int nv(input int i);  return (i == 0) ? 8 : 2; endfunction
   function automatic int per(input int i); return (i == 0) ? 2 : 1; endfunction

   function automatic logic [7:0] calc_tab(input int mode, input int n);
      logic [7:0] t = 8'h00;
      for (int k = 0; k < n; k++) t[k] = dut_fn(mode, 8'(k));
      return t;
   endfunction

   assign if_a.start    = start_v[0];
   assign if_a.expected = exp_v[0];
   assign if_a.dut_out  = dut_fn(mode_v[0], 8'(if_a.dut_in));
   assign if_b.start    = start_v[1];
   assign if_b.expected = exp_v[1][1:0];
   assign if_b.dut_out  = dut_fn(mode_v[1], 8'(if_b.dut_in));

   logic       o_busy [2];
   logic       o_done [2];
   logic       o_pass [2];
   logic [8:0] o_din  [2];
   logic [8:0] o_mcnt [2];
   logic [8:0] o_ff   [2];
   logic [8:0] o_capt [2];

   assign o_busy[0] = if_a.busy;  assign o_busy[1] = if_b.busy;
   assign o_done[0] = if_a.done;  assign o_done[1] = if_b.done;
   assign o_pass[0] = if_a.pass;  assign o_pass[1] = if_b.pass;
   assign o_din[0]  = 9'(if_a.dut_in);       assign o_din[1]  = 9'(if_b.dut_in);
   assign o_mcnt[0] = 9'(if_a.mismatch_cnt); assign o_mcnt[1] = 9'(if_b.mismatch_cnt);
   assign o_ff[0]   = 9'(if_a.first_fail);   assign o_ff[1]   = 9'(if_b.first_fail);
   assign o_capt[0] = 9'(if_a.captured);     assign o_capt[1] = 9'(if_b.captured);

   // Model: cycles since accept, number of vectors already sampled, table snapshot
   logic       m_busy [2];
   logic       m_done [2];
   int         m_c    [2];
   int         m_ns   [2];
   logic [7:0] m_tab  [2];
   logic [7:0] m_exp  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_c[i] <= 0;
            m_ns[i]   <= 0;    m_tab[i]  <= 8'h00; m_exp[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (!m_busy[i]) begin
               if (start_v[i]) begin
                  m_busy[i] <= 1'b1;
                  m_c[i]    <= 0;
                  m_ns[i]   <= 0;
                  m_exp[i]  <= exp_v[i] & 8'((1 << nv(i)) - 1);
                  m_tab[i]  <= calc_tab(mode_v[i], nv(i));
               end
            end else if (m_c[i] + 1 == nv(i) * per(i)) begin
               m_busy[i] <= 1'b0;
               m_done[i] <= 1'b1;
               m_ns[i]   <= nv(i);
               m_c[i]    <= 0;
            end else begin
               m_c[i] <= m_c[i] + 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      int         ns, cnt, ff, din;
      logic [8:0] mk;
      logic [7:0] diff;
      string      sfx;
      for (int i = 0; i < 2; i++) begin
         sfx  = (i == 0) ? "a" : "b";
         ns   = m_busy[i] ? m_c[i] / per(i) : m_ns[i];
         din  = m_busy[i] ? m_c[i] / per(i) : 0;
         mk   = (9'd1 << ns) - 9'd1;
         diff = (m_tab[i] ^ m_exp[i]) & mk[7:0];
         cnt  = $countones(diff);
         ff   = 0;
         for (int k = 7; k >= 0; k--) if (diff[k]) ff = k;
         chk({"busy_", sfx},   32'(o_busy[i]), 32'(m_busy[i]));
         chk({"done_", sfx},   32'(o_done[i]), 32'(m_done[i]));
         chk({"dut_in_", sfx}, 32'(o_din[i]),  32'(din));
         chk({"mcnt_", sfx},   32'(o_mcnt[i]), 32'(cnt));
         chk({"ffail_", sfx},  32'(o_ff[i]),   32'(ff));
         chk({"capt_", sfx},   32'(o_capt[i]), 32'(m_tab[i] & mk[7:0]));
         chk({"pass_", sfx},   32'(o_pass[i]), 32'(!m_busy[i] && ns == nv(i) && cnt == 0));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      #1;
   endtask

   // One sweep on instance a; optional start poke and expected-table change mid-sweep
   task automatic sweep_a(input int poke_start, input int poke_exp, input logic [7:0] new_exp,
                          output int nb, output int nd, output int done_at);
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      nb = 0; nd = 0; done_at = -1;
      for (int k = 0; k < 20; k++) begin
         if (o_busy[0]) nb++;
         if (o_done[0]) begin nd++; done_at = k; end
         start_v[0] = (k == poke_start);
         if (k == poke_exp) exp_v[0] = new_exp;
         tick();
      end
      start_v[0] = 1'b0;
   endtask

   initial begin
      int nb, nd, da, first_done;
      logic relaunched;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin start_v[i] = 1'b0; exp_v[i] = 8'h00; mode_v[i] = 0; end
      repeat (3) tick();
      chk("rst_busy", 32'(o_busy[0]), 32'd0);
      chk("rst_capt", 32'(o_capt[0]), 32'd0);
      rst_n = 1'b1;
      tick();

      // Good majority DUT
      exp_v[0] = 8'hE8; mode_v[0] = 0;
      sweep_a(-1, -1, 8'h00, nb, nd, da);
      chk("good_busy_cycles", 32'(nb), 32'd16);
      chk("good_done_count",  32'(nd), 32'd1);
      chk("good_done_cycle",  32'(da), 32'd16);
      chk("good_capt",  32'(o_capt[0]), 32'hE8);
      chk("good_mcnt",  32'(o_mcnt[0]), 32'd0);
      chk("good_ffail", 32'(o_ff[0]),   32'd0);
      chk("good_pass",  32'(o_pass[0]), 32'd1);

      // Stuck-at-0 DUT
      mode_v[0] = 1;
      sweep_a(-1, -1, 8'h00, nb, nd, da);
      chk("stuck_mcnt",  32'(o_mcnt[0]), 32'd4);
      chk("stuck_ffail", 32'(o_ff[0]),   32'd3);
      chk("stuck_capt",  32'(o_capt[0]), 32'h00);
      chk("stuck_pass",  32'(o_pass[0]), 32'd0);

      // Start while busy is ignored
      mode_v[0] = 0;
      sweep_a(4, -1, 8'h00, nb, nd, da);
      chk("busy_start_cycles", 32'(nb), 32'd16);
      chk("busy_start_dones",  32'(nd), 32'd1);
      chk("busy_start_pass",   32'(o_pass[0]), 32'd1);

      // Expected changes mid-sweep; snapshot must be used
      sweep_a(-1, 6, 8'h00, nb, nd, da);
      chk("snap_pass", 32'(o_pass[0]), 32'd1);
      chk("snap_mcnt", 32'(o_mcnt[0]), 32'd0);
      exp_v[0] = 8'hE8;

      // Reset in cycle 9 of a sweep
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(o_busy[0]), 32'd0);
      chk("arst_din",  32'(o_din[0]),  32'd0);
      chk("arst_capt", 32'(o_capt[0]), 32'd0);
      chk("arst_mcnt", 32'(o_mcnt[0]), 32'd0);
      chk("arst_done", 32'(o_done[0]), 32'd0);
      nd = 0;
      for (int k = 0; k < 3; k++) begin tick(); if (o_done[0]) nd++; end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); if (o_done[0]) nd++; end
      chk("arst_no_done", 32'(nd), 32'd0);
      sweep_a(-1, -1, 8'h00, nb, nd, da);
      chk("post_rst_cycles", 32'(nb), 32'd16);
      chk("post_rst_capt",   32'(o_capt[0]), 32'hE8);
      chk("post_rst_pass",   32'(o_pass[0]), 32'd1);

      // Instance b: NOT DUT, then buffer with start in the done cycle
      exp_v[1] = 8'h01; mode_v[1] = 2;
      start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      nb = 0; nd = 0; first_done = -1; relaunched = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (o_busy[1]) nb++;
         if (o_done[1]) nd++;
         if (o_done[1] && !relaunched) begin
            first_done = k;
            chk("b_first_pass", 32'(o_pass[1]), 32'd1);
            chk("b_first_mcnt", 32'(o_mcnt[1]), 32'd0);
            mode_v[1]  = 3;
            start_v[1] = 1'b1;
            relaunched = 1'b1;
         end else begin
            start_v[1] = 1'b0;
         end
         tick();
      end
      chk("b_first_done_cycle", 32'(first_done), 32'd2);
      chk("b_busy_cycles", 32'(nb), 32'd4);
      chk("b_done_count",  32'(nd), 32'd2);
      chk("b2b_mcnt",  32'(o_mcnt[1]), 32'd2);
      chk("b2b_ffail", 32'(o_ff[1]),   32'd0);
      chk("b2b_pass",  32'(o_pass[1]), 32'd0);
      chk("b2b_capt",  32'(o_capt[1]), 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Self-checking exhaustive stimulus engine for small combinational functions.
- Parametrised, synthesizable successor to manual truth-table benches.
- Drives every input combination 0 .. 2^N_IN-1 into a DUT in ascending order and holds each vector for a programmable settle time.
- Samples the DUT's 1-bit response, builds the observed truth table and compares it against a supplied expected table.
- Reports pass/fail, mismatch count and first failing vector. Sits between a test controller and any N-input, 1-output function.

Parameters:
- N_IN, 3, number of DUT inputs; legal 1..8.
- SETTLE, 1, extra hold cycles per vector before sampling; legal 0..15. Each vector is held SETTLE+1 cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; sampled only when busy=0.
- expected  input  2^N_IN  expected truth table; bit k = F(vector k); snapshotted on start accept.
- dut_in  output  N_IN  current stimulus vector.
- dut_out  input  1  DUT response.
- busy  output  1  high while a sweep runs.
- done  output  1  one-cycle pulse after the last sample.
- pass  output  1  1 if the last completed sweep had zero mismatches.
- mismatch_cnt  output  N_IN+1  mismatches in the last or current sweep; range 0..2^N_IN.
- first_fail  output  N_IN  index of the first mismatching vector; valid when mismatch_cnt != 0, else 0.
- captured  output  2^N_IN  observed truth table; bit k = sampled dut_out for vector k.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - dut_in, busy, done, pass, mismatch_cnt, first_fail, captured and the hold counter all go to 0.
  - The expected snapshot also goes to 0.
  - A reset mid-sweep aborts the sweep immediately. No done pulse is produced; results read as 0.
- States: IDLE, RUN. DONE is not a state; done is a registered pulse.
- Start accept: at any edge with start=1 and busy=0 (IDLE):
  - expected_q <= expected, busy <= 1, dut_in <= 0, hold <= 0.
  - captured, mismatch_cnt, first_fail and pass are cleared. Go to RUN.
- start while busy=1 is ignored. No restart, no queuing.
- RUN, hold < SETTLE: hold <= hold+1; dut_in stable.
- RUN, hold == SETTLE (sample edge):
  - captured[dut_in] <= dut_out.
  - If dut_out != expected_q[dut_in]: mismatch_cnt <= mismatch_cnt+1.
  - first_fail <= dut_in, only if mismatch_cnt was 0.
  - If dut_in != 2^N_IN-1: dut_in <= dut_in+1, hold <= 0.
  - If dut_in == 2^N_IN-1 (wrap boundary): dut_in <= 0, busy <= 0, done <= 1, go to IDLE.
  - pass <= 1 only if the final mismatch total, including this sample, is 0.
- Latency:
  - Sweep occupies exactly 2^N_IN*(SETTLE+1) cycles after the accept edge.
  - done is high in the following cycle.
  - Example: N_IN=3, SETTLE=1 gives 16 busy cycles.
- done is a single-cycle pulse.
- A start on the same edge where done=1 is accepted, since busy=0. Results clear and a new sweep begins.
- Results (pass, mismatch_cnt, first_fail, captured) hold stable in IDLE until the next accept or reset.
- mismatch_cnt is N_IN+1 bits so that 2^N_IN cannot overflow. No saturation logic is needed.
- SETTLE=0: each vector is applied and sampled in a single cycle.
- dut_out is assumed settled by the sample edge. No synchronizer is included (same clock domain).

Decomposition:
- Shared package or include file holds:
  - FSM state encodings ST_IDLE=1'b0, ST_RUN=1'b1.
  - Localparams NVEC = 1<<N_IN and CNT_W = N_IN+1, derived in-module from the parameter.
- No sub-module is natural. Implement as one FSM with hold counter, vector counter and compare/capture datapath.
- The bench supplies a behavioural DUT model.

Test Plan:
- Good DUT, N_IN=3, SETTLE=1, DUT = majority(A,B,C), expected=8'hE8, start pulsed once
  -> busy high 16 cycles; dut_in steps 0..7, each held 2 cycles; done pulses in cycle 17; pass=1, mismatch_cnt=0, first_fail=0, captured=8'hE8.
- Stuck-at-0 DUT, expected=8'hE8
  -> mismatch_cnt=4, first_fail=3, pass=0, captured=8'h00.
- Start while busy: pulse start again at cycle 5 of a sweep
  -> ignored; sweep still ends at cycle 16; exactly one done pulse.
- Reset mid-sweep: rst_n=0 at cycle 9
  -> all outputs 0 asynchronously; no done; a later start runs a full clean sweep.
- Corner parameters, N_IN=1, SETTLE=0, DUT = NOT, expected=2'b01
  -> 2-cycle sweep, pass=1.
  - Then change DUT to buffer and assert start in the done cycle -> back-to-back sweep accepted; mismatch_cnt=2, first_fail=0, pass=0.
- Expected snapshot: change the expected input mid-sweep
  -> results still judged against the value latched at start.
